nrzi_line_decoder: RTL and testbench

//  Receive-side counterpart of the team's toggle-state line encoder. Recovers data bits from
//  the encoded serial line, hunts for a sync word, then deserialises WORD_W-bit data words
//  and hands them out over a valid/ready interface. Sits between the line input pin stage and
//  the word-level consumer.

---
 rtl/nrzi_line_decoder_if.sv | 21 ++
 rtl/nrzi_line_decoder.sv | 115 +++++++++++
 tb/tb_nrzi_line_decoder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/nrzi_line_decoder_if.sv
// Word-level output stream of the NRZI line decoder.
// The decoder drives it through the master modport. The consumer uses the slave modport.
interface nrzi_line_decoder_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_out,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_out,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/nrzi_line_decoder.sv
// Toggle-state line decoder: recovers bits, hunts for the sync word, then deserialises
// words LSB-first into a one-entry holding register with a valid/ready handshake.
module nrzi_line_decoder #(
  parameter int                WORD_W   = 8,
  parameter logic [WORD_W-1:0] SYNC_PAT = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  line_in,
  input  logic                  resync,
  nrzi_line_decoder_if.master   word_bus,
  output logic                  locked,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);

  typedef enum logic {HUNT, DATA} state_t;

  state_t            state_reg, state_next;
  logic              s_reg, s_next;
  logic [WORD_W-1:0] shreg_reg, shreg_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [WORD_W-1:0] word_out_reg;
  logic              word_valid_reg;
  logic              overrun_reg;

  logic              bit_d;
  logic [WORD_W-1:0] shifted;
  logic              word_done;

  assign bit_d   = line_in ^ s_reg;
  assign shifted = {bit_d, shreg_reg[WORD_W-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= HUNT;
      s_reg       <= 1'b0;
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      s_reg       <= s_next;
      shreg_reg   <= shreg_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  // resync wins over decode; the line bit sampled alongside it is thrown away.
  always_comb begin
    state_next   = state_reg;
    s_next       = s_reg;
    shreg_next   = shreg_reg;
    bit_cnt_next = bit_cnt_reg;
    word_done    = 1'b0;
    if (resync) begin
      state_next   = HUNT;
      s_next       = 1'b0;
      shreg_next   = '0;
      bit_cnt_next = '0;
    end else if (enable) begin
      s_next     = s_reg ^ ~bit_d;
      shreg_next = shifted;
      case (state_reg)
        HUNT: begin
          if (bit_cnt_reg >= CNT_LAST && shifted == SYNC_PAT) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end else if (bit_cnt_reg != CNT_FULL) begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt_reg == CNT_LAST) begin
            word_done    = 1'b1;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // A finished word loads straight from the shifter, so word_valid rises on the last-bit edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_out_reg   <= '0;
      word_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      if (word_done && (!word_valid_reg || word_bus.word_ready)) begin
        word_out_reg   <= shifted;
        word_valid_reg <= 1'b1;
      end else if (word_valid_reg && word_bus.word_ready) begin
        word_valid_reg <= 1'b0;
      end
      if (resync) begin
        overrun_reg <= 1'b0;
      end else if (word_done && word_valid_reg && !word_bus.word_ready) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign word_bus.word_out   = word_out_reg;
  assign word_bus.word_valid = word_valid_reg;
  assign locked              = (state_reg == DATA);
  assign overrun             = overrun_reg;

endmodule

// File: tb/tb_nrzi_line_decoder.sv
// Directed bench for nrzi_line_decoder: sync hunt, word delivery, backpressure/overrun,
// same-cycle handshake, gapped enable, resync and asynchronous reset.
module tb_nrzi_line_decoder;

  logic clk;
  logic reset;
  logic enable;
  logic line_in;
  logic resync;
  logic locked;
  logic overrun;

  int n_cmp = 0;
  int n_bad = 0;
  logic line_s = 1'b0;

  nrzi_line_decoder_if #(.WORD_W(8)) bus ();

  nrzi_line_decoder #(.WORD_W(8), .SYNC_PAT(8'hA5)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .line_in  (line_in),
    .resync   (resync),
    .word_bus (bus),
    .locked   (locked),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("check %s ok (0x%0h)", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one enabled line bit and keep the bench-side encoder state in step.
  task automatic send_line(input logic l);
    logic d;
    enable  = 1'b1;
    line_in = l;
    tick();
    enable  = 1'b0;
    d       = l ^ line_s;
    line_s  = line_s ^ ~d;
  endtask

  task automatic send_bit(input logic d);
    send_line(d ^ line_s);
  endtask

  task automatic send_word(input logic [7:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(w[i]);
    $display("sent %0d bits of 0x%02h", nbits, w);
  endtask

  task automatic idle();
    enable = 1'b0;
    tick();
  endtask

  task automatic do_resync(input logic l);
    resync  = 1'b1;
    enable  = 1'b1;
    line_in = l;
    tick();
    resync  = 1'b0;
    enable  = 1'b0;
    line_s  = 1'b0;
  endtask

  logic [7:0] sync_line;
  logic [7:0] zero_line;
  logic [7:0] w;

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    line_in = 1'b0;
    resync = 1'b0;
    bus.word_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(bus.word_valid), 32'd0);
    check("rst_word", 32'(bus.word_out), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    tick();

    // 1: sync word as hand-encoded line bits, first bit in bit 0
    sync_line = 8'b1100_1001;
    for (int i = 0; i < 7; i++) send_line(sync_line[i]);
    check("sync_7bits_locked", 32'(locked), 32'd0);
    send_line(sync_line[7]);
    check("sync_locked", 32'(locked), 32'd1);
    check("sync_not_output", 32'(bus.word_valid), 32'd0);

    // 2: 0x00 as line 0,1,0,1,... then 0xFF as all ones
    zero_line = 8'b1010_1010;
    for (int i = 0; i < 7; i++) send_line(zero_line[i]);
    check("w00_7bits_valid", 32'(bus.word_valid), 32'd0);
    send_line(zero_line[7]);
    check("w00_valid", 32'(bus.word_valid), 32'd1);
    check("w00_word", 32'(bus.word_out), 32'h00);
    bus.word_ready = 1'b1;
    idle();
    bus.word_ready = 1'b0;
    check("w00_consumed", 32'(bus.word_valid), 32'd0);
    for (int i = 0; i < 8; i++) send_line(1'b1);
    check("wff_valid", 32'(bus.word_valid), 32'd1);
    check("wff_word", 32'(bus.word_out), 32'hFF);
    bus.word_ready = 1'b1;
    idle();
    bus.word_ready = 1'b0;

    // 3: backpressure, second word dropped
    send_word(8'h3C, 8);
    check("w3c_word", 32'(bus.word_out), 32'h3C);
    check("w3c_overrun", 32'(overrun), 32'd0);
    send_word(8'hC3, 8);
    check("drop_word_held", 32'(bus.word_out), 32'h3C);
    check("drop_valid", 32'(bus.word_valid), 32'd1);
    check("drop_overrun", 32'(overrun), 32'd1);
    bus.word_ready = 1'b1;
    idle();
    bus.word_ready = 1'b0;
    check("drop_consumed", 32'(bus.word_valid), 32'd0);
    check("overrun_sticky", 32'(overrun), 32'd1);
    do_resync(1'b1);
    check("resync_overrun_clr", 32'(overrun), 32'd0);
    check("resync_unlocked", 32'(locked), 32'd0);
    send_word(8'hA5, 8);
    check("relock1", 32'(locked), 32'd1);

    // 4: last bit lands in the handshake cycle
    send_word(8'h5A, 8);
    check("w5a_word", 32'(bus.word_out), 32'h5A);
    w = 8'h96;
    send_word(w, 7);
    check("w96_7bits_held", 32'(bus.word_out), 32'h5A);
    bus.word_ready = 1'b1;
    send_bit(w[7]);
    check("w96_word", 32'(bus.word_out), 32'h96);
    check("w96_valid", 32'(bus.word_valid), 32'd1);
    check("w96_no_overrun", 32'(overrun), 32'd0);
    send_word(8'h0F, 8);
    check("w0f_word", 32'(bus.word_out), 32'h0F);
    check("w0f_valid", 32'(bus.word_valid), 32'd1);
    check("w0f_no_overrun", 32'(overrun), 32'd0);
    idle();
    check("w0f_consumed", 32'(bus.word_valid), 32'd0);
    bus.word_ready = 1'b0;

    // 5: gapped enable with garbage on the idle line
    w = 8'hB4;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i]);
      line_in = ~line_in;
      idle();
    end
    check("gapped_word", 32'(bus.word_out), 32'hB4);
    check("gapped_valid", 32'(bus.word_valid), 32'd1);
    send_word(8'h6D, 3);
    do_resync(1'b1);
    check("mid_resync_locked", 32'(locked), 32'd0);
    check("mid_resync_s", 32'(dut.s_reg), 32'd0);
    check("mid_resync_cnt", 32'(dut.bit_cnt_reg), 32'd0);
    check("mid_resync_held_valid", 32'(bus.word_valid), 32'd1);
    check("mid_resync_held_word", 32'(bus.word_out), 32'hB4);
    bus.word_ready = 1'b1;
    idle();
    bus.word_ready = 1'b0;
    send_word(8'hA5, 8);
    check("relock2", 32'(locked), 32'd1);
    send_word(8'h21, 8);
    check("w21_word", 32'(bus.word_out), 32'h21);
    bus.word_ready = 1'b1;
    idle();
    bus.word_ready = 1'b0;
    w = 8'h77;
    send_word(w, 7);
    do_resync(w[7] ^ line_s);
    check("done_on_resync_dropped", 32'(bus.word_valid), 32'd0);
    check("done_on_resync_locked", 32'(locked), 32'd0);

    // 6: asynchronous reset mid-word with a word held
    send_word(8'hA5, 8);
    check("relock3", 32'(locked), 32'd1);
    send_word(8'hE7, 8);
    check("we7_word", 32'(bus.word_out), 32'hE7);
    send_word(8'h18, 4);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(bus.word_valid), 32'd0);
    check("arst_word", 32'(bus.word_out), 32'd0);
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    check("arst_cnt", 32'(dut.bit_cnt_reg), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
